// File: rtl/mario_pkg.sv
// mario_pkg: button bit positions and the pad polling FSM state type.
package mario_pkg;
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  typedef enum logic [2:0] {
    PAD_IDLE,
    PAD_LATCH,
    PAD_SAMPLE,
    PAD_CLK_HI,
    PAD_CLK_LO,
    PAD_UPDATE
  } pad_state_t;
endpackage

// File: rtl/pad_sync.sv
// pad_sync: 2-flop synchronizer for the pad data line; resets to 1 (button released).
module pad_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, m} <= 2'b11;
    else {q, m} <= {m, d};
endmodule

// File: rtl/nes_pad_reader.sv
// nes_pad_reader: polls a serial NES pad and decodes move/jump/start commands.
// Define PAD_DEBOUNCE_EN to commit buttons only after two identical consecutive frames.
module nes_pad_reader
  import mario_pkg::*;
#(
  parameter int CLK_HALF     = 4,
  parameter int LATCH_CYCLES = 6,
  parameter int POLL_PERIOD  = 833333
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic       frame_valid,
  output logic       move_left,
  output logic       move_right,
  output logic       jump,
  output logic       start_game
);
  localparam int FRAME_LEN = LATCH_CYCLES + 8 + 14 * CLK_HALF + 1;
  localparam int PW = $clog2(POLL_PERIOD);
  localparam int HW = $clog2(CLK_HALF + LATCH_CYCLES);
  if (FRAME_LEN >= POLL_PERIOD || CLK_HALF < 3 || LATCH_CYCLES < 3) begin : g_bad_cfg
    $error("nes_pad_reader: invalid CLK_HALF/LATCH_CYCLES/POLL_PERIOD");
  end
  pad_state_t state, nxt;
  logic [PW-1:0] cnt;
  logic [HW-1:0] ph;
  logic [2:0] idx;
  logic [7:0] sr;
  logic sync_data, commit;
  pad_sync u_sync (.clk(clk), .rst_n(rst_n), .d(pad_data), .q(sync_data));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= PAD_IDLE;
      cnt   <= '0;
      ph    <= '0;
      idx   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt == PW'(POLL_PERIOD - 1) ? '0 : cnt + 1'b1;
      ph    <= nxt == state ? ph + 1'b1 : '0;
      idx   <= state == PAD_IDLE ? 3'd0 : state == PAD_SAMPLE ? idx + 3'd1 : idx;
    end
  always_comb begin
    nxt         = state;
    pad_latch   = state == PAD_LATCH;
    pad_clk     = state == PAD_CLK_HI;
    frame_valid = state == PAD_UPDATE && commit;
    unique case (state)
      PAD_IDLE:   nxt = cnt == '0 ? PAD_LATCH : PAD_IDLE;
      PAD_LATCH:  nxt = ph == HW'(LATCH_CYCLES - 1) ? PAD_SAMPLE : PAD_LATCH;
      PAD_SAMPLE: nxt = idx == 3'd7 ? PAD_UPDATE : PAD_CLK_HI;
      PAD_CLK_HI: nxt = ph == HW'(CLK_HALF - 1) ? PAD_CLK_LO : PAD_CLK_HI;
      PAD_CLK_LO: nxt = ph == HW'(CLK_HALF - 1) ? PAD_SAMPLE : PAD_CLK_LO;
      default:    nxt = PAD_IDLE;
    endcase
  end
`ifdef PAD_DEBOUNCE_EN
  logic [7:0] raw_prev;
  logic prev_ok;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      raw_prev <= '0;
      prev_ok  <= 1'b0;
    end else if (state == PAD_UPDATE) begin
      raw_prev <= sr;
      prev_ok  <= 1'b1;
    end
  assign commit = prev_ok && sr == raw_prev;
`else
  assign commit = 1'b1;
`endif
  // Commands are derived from the capture itself so they land together with the new buttons.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr         <= '0;
      buttons    <= '0;
      move_left  <= 1'b0;
      move_right <= 1'b0;
      jump       <= 1'b0;
      start_game <= 1'b0;
    end else begin
      if (state == PAD_SAMPLE) sr[idx] <= ~sync_data;
      start_game <= frame_valid & sr[BTN_START] & ~buttons[BTN_START];
      if (frame_valid) begin
        buttons    <= sr;
        move_left  <= sr[BTN_LEFT] & ~sr[BTN_RIGHT];
        move_right <= sr[BTN_RIGHT] & ~sr[BTN_LEFT];
        jump       <= sr[BTN_A];
      end
    end
endmodule

// File: tb/tb_nes_pad_reader.sv
// tb_nes_pad_reader: directed checks of pad timing, decode, start pulse, mid-frame reset and debounce.
module tb_nes_pad_reader;
  logic clk = 1'b0, rst_n = 1'b0, pad_data;
  logic pad_latch, pad_clk, frame_valid, move_left, move_right, jump, start_game;
  logic [7:0] buttons;
  logic [7:0] pressed = 8'h00, sh = 8'hFF;
  logic pclk_q = 1'b0;
  int checks = 0, failures = 0, m = 0;
  int fvs, pulses, sgs, fv_at;
  always #5 clk = ~clk;
  nes_pad_reader #(.CLK_HALF(4), .LATCH_CYCLES(6), .POLL_PERIOD(200)) dut (
    .clk(clk), .rst_n(rst_n), .pad_data(pad_data), .pad_latch(pad_latch), .pad_clk(pad_clk),
    .buttons(buttons), .frame_valid(frame_valid), .move_left(move_left), .move_right(move_right),
    .jump(jump), .start_game(start_game)
  );
  always @(posedge clk) begin
    pclk_q <= pad_clk;
    if (pad_latch) sh <= ~pressed;
    else if (pad_clk && !pclk_q) sh <= {1'b1, sh[7:1]};
  end
  assign pad_data = sh[0];
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (m=%0d)", tag, obs, exp, m);
    end
  endtask
  function automatic int exp_latch(input int t);
    return int'((t % 200) >= 1 && (t % 200) <= 6);
  endfunction
  function automatic int exp_clk(input int t);
    int r;
    r = t % 200;
    return int'(r >= 8 && r < 70 && ((r - 7) % 9) >= 1 && ((r - 7) % 9) <= 4);
  endfunction
  task automatic run(input int k);
    logic prev;
    prev = pad_clk;
    fvs = 0; pulses = 0; sgs = 0; fv_at = -1;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      m++;
      chk("pad_latch", int'(pad_latch), exp_latch(m));
      chk("pad_clk", int'(pad_clk), exp_clk(m));
      if (pad_latch && pad_clk) chk("latch_clk_overlap", 1, 0);
      if (pad_clk && !prev) pulses++;
      prev = pad_clk;
      if (frame_valid) begin fvs++; fv_at = m % 200; end
      sgs += int'(start_game);
    end
  endtask
  task automatic outs(input string tag, input logic [7:0] eb, input logic eml, emr, ej, esg);
    chk({tag, ".buttons"}, int'(buttons), int'(eb));
    chk({tag, ".move_left"}, int'(move_left), int'(eml));
    chk({tag, ".move_right"}, int'(move_right), int'(emr));
    chk({tag, ".jump"}, int'(jump), int'(ej));
    chk({tag, ".start_game"}, int'(start_game), int'(esg));
  endtask
  task automatic counts(input string tag, input int efv, input int esg);
    chk({tag, ".fv_count"}, fvs, efv);
    if (efv != 0) chk({tag, ".fv_cycle"}, fv_at, 71);
    chk({tag, ".pclk_pulses"}, pulses, 7);
    chk({tag, ".sg_count"}, sgs, esg);
  endtask
  task automatic release_frame(input string tag, input logic [7:0] eb, input logic eml, emr, ej, input int efv);
    m = 0;
    rst_n = 1'b1;
    run(72);
    counts(tag, efv, 0);
    outs(tag, eb, eml, emr, ej, 1'b0);
  endtask
  task automatic frame(input string tag, input logic [7:0] p, eb, input logic eml, emr, ej, esg, input int efv);
    pressed = p;
    run(200);
    counts(tag, efv, int'(esg));
    outs(tag, eb, eml, emr, ej, esg);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst.latch", int'(pad_latch), 0);
    chk("rst.pclk", int'(pad_clk), 0);
    chk("rst.fv", int'(frame_valid), 0);
    outs("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
`ifndef PAD_DEBOUNCE_EN
    release_frame("f0", 8'h00, 1'b0, 1'b0, 1'b0, 1);
    frame("left", 8'h40, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    frame("lra", 8'hC1, 8'hC1, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    frame("start1", 8'h08, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    frame("start2", 8'h08, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    frame("start3", 8'h08, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    frame("rel", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    frame("repress", 8'h08, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    pressed = 8'h81;
    run(164);
    chk("mid.pclk_hi", int'(pad_clk), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid.latch", int'(pad_latch), 0);
    chk("mid.pclk", int'(pad_clk), 0);
    chk("mid.fv", int'(frame_valid), 0);
    outs("mid", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    release_frame("after_rst", 8'h81, 1'b0, 1'b1, 1'b1, 1);
    frame("right_a", 8'h81, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 1);
`else
    release_frame("db0", 8'h00, 1'b0, 1'b0, 1'b0, 0);
    frame("db1", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    frame("glitch", 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    frame("db3", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    frame("db4", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    frame("a_1st", 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    frame("a_2nd", 8'h01, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
